gate_test_sequencer: RTL and testbench

- Controller that exercises a 2-input logic gate instance (default target: and_gate) on the Basys 3 board.
- Steps the gate inputs a/b through the full 2-bit truth table in order 00, 01, 10, 11. Holds each vector for a programmable dwell time, then samples the gate output y.
- Compares each sample against a 4-bit expected truth table and reports a pass flag plus a saturating error count.
- Sits between board controls (start/abort buttons, already debounced and single-cycle-pulsed upstream) and the gate under test; its outputs drive LEDs.

---
 rtl/gate_test_sequencer.sv | 133 +++++++++++++
 tb/tb_gate_test_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
// Steps a 2-input gate through its truth table, samples y after a dwell period
// and scores each sample against an expected table.
module gate_test_sequencer #(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned LOOPS        = 1,
    parameter int unsigned ERR_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       exp_tt,
    input  logic             y_in,
    output logic             a_out,
    output logic             b_out,
    output logic [1:0]       vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [LW-1:0] LOOP_LAST  = LW'(LOOPS - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [LW-1:0]    loop_q, loop_d;
    logic [1:0]       vec_q, vec_d;
    logic             smp_q, smp_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            dwell_q <= '0;
            loop_q  <= '0;
            vec_q   <= '0;
            smp_q   <= 1'b0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
            vec_q   <= vec_d;
            smp_q   <= smp_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
        vec_d   = vec_q;
        smp_d   = smp_q;
        err_d   = err_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSettle;
                    vec_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    dwell_d = '0;
                    loop_d  = '0;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                    vec_d   = '0;
                    dwell_d = '0;
                    pass_d  = 1'b0;
                end else if (dwell_q == DWELL_LAST) begin
                    smp_d   = y_in;
                    dwell_d = '0;
                    state_d = StCheck;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            StCheck: begin
                // Abort discards this cycle's score update.
                if (abort) begin
                    state_d = StIdle;
                    vec_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    if ((smp_q != exp_tt[vec_q]) && (err_q != '1)) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (vec_q == 2'd3) begin
                        if (loop_q == LOOP_LAST) begin
                            state_d = StDone;
                        end else begin
                            vec_d   = '0;
                            loop_d  = loop_q + LW'(1);
                            state_d = StSettle;
                        end
                    end else begin
                        vec_d   = vec_q + 2'd1;
                        state_d = StSettle;
                    end
                end
            end
            StDone: begin
                pass_d  = (err_q == '0);
                vec_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Gate inputs mirror the registered vector index.
    assign a_out     = vec_q[1];
    assign b_out     = vec_q[0];
    assign vec_idx   = vec_q;
    assign busy      = (state_q == StSettle) || (state_q == StCheck);
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench: one DUT with defaults (LOOPS=1) and one with LOOPS=8 for saturation.
module tb_gate_test_sequencer;

    logic       clk;
    logic       rst;
    logic       start, abort;
    logic [3:0] exp_tt;
    logic       y_in;
    logic       a_out, b_out, busy, done, pass;
    logic [1:0] vec_idx;
    logic [3:0] err_count;
    logic       y_mode, force_val;

    logic       start8, abort8;
    logic [3:0] exp_tt8;
    logic       y8;
    logic       a8, b8, busy8, done8, pass8;
    logic [1:0] vec8;
    logic [3:0] err8;

    int n_checks;
    int n_pass;

    assign y_in = y_mode ? force_val : (a_out & b_out);
    assign y8   = ~(a8 & b8);

    gate_test_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .exp_tt    (exp_tt),
        .y_in      (y_in),
        .a_out     (a_out),
        .b_out     (b_out),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
    );

    gate_test_sequencer #(
        .DWELL_CYCLES (4),
        .LOOPS        (8),
        .ERR_W        (4)
    ) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .abort     (abort8),
        .exp_tt    (exp_tt8),
        .y_in      (y8),
        .a_out     (a8),
        .b_out     (b8),
        .vec_idx   (vec8),
        .busy      (busy8),
        .done      (done8),
        .pass      (pass8),
        .err_count (err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks from edge 'from' up to 'max' (edges counted from the one before start
    // was raised); optionally re-pulses start at 'extra'. Returns first done edge or -1.
    task automatic wait_done(input int sel, input int from, input int max, input int extra,
                             output int done_at);
        done_at = -1;
        for (int n = from; n <= max; n++) begin
            tick();
            start  = (sel == 0) && (n == extra);
            start8 = (sel == 1) && (n == extra);
            if (((sel == 0) ? done : done8) && done_at < 0) begin
                done_at = n;
                break;
            end
        end
        start  = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({a_out, b_out, vec_idx, busy, done, pass, err_count} !== 11'd0)
            $display("FAIL reset_outputs got=%b want=0",
                     {a_out, b_out, vec_idx, busy, done, pass, err_count});
        else n_pass++;
        n_checks++;
        if ({busy8, done8, pass8, err8, vec8} !== 9'd0)
            $display("FAIL reset_outputs8 got=%b want=0", {busy8, done8, pass8, err8, vec8});
        else n_pass++;
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic test_and_pass();
        logic [1:0] exp_ab;
        y_mode = 1'b0;
        exp_tt = 4'b1000;
        start  = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            tick();
            start = 1'b0;
            if (n <= 20) begin
                exp_ab = 2'((n - 1) / 5);
                n_checks++;
                if ({a_out, b_out} !== exp_ab || busy !== 1'b1)
                    $display("FAIL and_seq n=%0d ab=%b busy=%b want ab=%b busy=1",
                             n, {a_out, b_out}, busy, exp_ab);
                else n_pass++;
            end
            n_checks++;
            if (done !== (n == 21))
                $display("FAIL and_done n=%0d got=%b want=%b", n, done, (n == 21));
            else n_pass++;
        end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 4'd0 || {a_out, b_out, busy} !== 3'b000)
            $display("FAIL and_result pass=%b err=%0d ab=%b busy=%b want pass=1 err=0 ab=00 busy=0",
                     pass, err_count, {a_out, b_out}, busy);
        else n_pass++;
    endtask

    task automatic test_stuck_zero();
        int d;
        y_mode    = 1'b1;
        force_val = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (pass !== 1'b0 || busy !== 1'b1)
            $display("FAIL stuck_start pass=%b busy=%b want pass=0 busy=1", pass, busy);
        else n_pass++;
        wait_done(0, 2, 40, -1, d);
        n_checks++;
        if (d !== 21) $display("FAIL stuck_done_at got=%0d want=21", d);
        else n_pass++;
        tick();
        n_checks++;
        if (pass !== 1'b0 || err_count !== 4'd1)
            $display("FAIL stuck_result pass=%b err=%0d want pass=0 err=1", pass, err_count);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int d;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done(1, 2, 200, -1, d);
        n_checks++;
        if (d !== 161) $display("FAIL sat_done_at got=%0d want=161", d);
        else n_pass++;
        tick();
        n_checks++;
        if (err8 !== 4'd15 || pass8 !== 1'b0 || busy8 !== 1'b0)
            $display("FAIL sat_result err=%0d pass=%b busy=%b want err=15 pass=0 busy=0",
                     err8, pass8, busy8);
        else n_pass++;
    endtask

    task automatic test_abort();
        int d;
        y_mode    = 1'b1;
        force_val = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        n_checks++;
        if (vec_idx !== 2'd2 || busy !== 1'b1 || err_count !== 4'd2)
            $display("FAIL abort_pre vec=%0d busy=%b err=%0d want vec=2 busy=1 err=2",
                     vec_idx, busy, err_count);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({busy, a_out, b_out, vec_idx, pass} !== 6'd0 || err_count !== 4'd2)
            $display("FAIL abort_post busy=%b ab=%b vec=%0d pass=%b err=%0d want 0,00,0,0,2",
                     busy, {a_out, b_out}, vec_idx, pass, err_count);
        else n_pass++;
        wait_done(0, 14, 45, -1, d);
        n_checks++;
        if (d !== -1) $display("FAIL abort_no_done got done at %0d want none", d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d;
        y_mode    = 1'b1;
        force_val = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done(0, 2, 40, 7, d);
        n_checks++;
        if (d !== 21) $display("FAIL b2b_done_at got=%0d want=21", d);
        else n_pass++;
        tick();
        n_checks++;
        if (pass !== 1'b0 || err_count !== 4'd1)
            $display("FAIL b2b_first pass=%b err=%0d want pass=0 err=1", pass, err_count);
        else n_pass++;
        y_mode = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (err_count !== 4'd0 || pass !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_restart err=%0d pass=%b busy=%b want err=0 pass=0 busy=1",
                     err_count, pass, busy);
        else n_pass++;
        wait_done(0, 2, 40, -1, d);
        n_checks++;
        if (d !== 21) $display("FAIL b2b_second_done_at got=%0d want=21", d);
        else n_pass++;
        tick();
        n_checks++;
        if (pass !== 1'b1 || err_count !== 4'd0)
            $display("FAIL b2b_second pass=%b err=%0d want pass=1 err=0", pass, err_count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int d;
        y_mode    = 1'b1;
        force_val = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        n_checks++;
        if (vec_idx !== 2'd1 || err_count !== 4'd1 || busy !== 1'b1)
            $display("FAIL arst_pre vec=%0d err=%0d busy=%b want vec=1 err=1 busy=1",
                     vec_idx, err_count, busy);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({a_out, b_out, vec_idx, busy, done, pass, err_count} !== 11'd0)
            $display("FAIL arst_immediate got=%b want=0",
                     {a_out, b_out, vec_idx, busy, done, pass, err_count});
        else n_pass++;
        #2 rst = 1'b0;
        tick();
        y_mode = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        wait_done(0, 2, 40, -1, d);
        n_checks++;
        if (d !== 21) $display("FAIL arst_rerun_done_at got=%0d want=21", d);
        else n_pass++;
        tick();
        n_checks++;
        if (pass !== 1'b1 || err_count !== 4'd0)
            $display("FAIL arst_rerun pass=%b err=%0d want pass=1 err=0", pass, err_count);
        else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        exp_tt    = 4'b1000;
        y_mode    = 1'b0;
        force_val = 1'b0;
        start8    = 1'b0;
        abort8    = 1'b0;
        exp_tt8   = 4'b1000;
        test_reset();
        test_and_pass();
        test_stuck_zero();
        test_saturate();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
